nios2_c_cpu_mul_seq: RTL and testbench
======================================

# nios2_c_cpu_mul_seq

Multi-cycle multiply sequencer for the Nios II core in `nios2_c`. It time-shares a single registered 16x16 unsigned multiplier. Over consecutive cycles it issues the four 16-bit partial products of a 32x32 multiply, accumulates them into a 64-bit product, and applies signed correction. It returns the low word (`mul`) or the high word (`mulxuu`/`mulxsu`/`mulxss`) over a valid/ready handshake. It sits between the A-stage issue logic and the writeback mux and replaces the two-multiplier split cell on area-constrained builds.

## Interface
Parameters:
- `MUL_PIPE`, default 1: register stages inside the 16x16 multiplier. Legal values are 1 or 2.

Ports:
- `clk`  in  1  clock. Single clock; the block uses no other clock.
- `reset_n`  in  1  reset. Synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request. Equals (state == IDLE).
- `req_op`  in  2  operation: 00 `mul` (low word), 01 `mulxuu`, 10 `mulxsu` (src1 signed, src2 unsigned), 11 `mulxss`.
- `req_src1`  in  32  operand A.
- `req_src2`  in  32  operand B.
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_result`  out  32  selected product word.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Accept:** a request is accepted on a clock edge where `req_valid & req_ready` is high. At that edge the block latches `src1`, `src2` and `op`, clears the 64-bit accumulator `acc`, and sets issue counter `k` to 0.
- **State machine:** IDLE -> ISSUE -> DRAIN -> FIX -> DONE -> IDLE.
- **ISSUE:**
  - One partial product is issued per cycle, in order k=0 LL (A[15:0]·B[15:0]), k=1 HL (A[31:16]·B[15:0]), k=2 LH (A[15:0]·B[31:16]), k=3 HH (A[31:16]·B[31:16]).
  - For `op`=00, HH is not issued. ISSUE ends after k=2.
  - Each product p[31:0] returns `MUL_PIPE` cycles after issue and is added to `acc`, shifted by the amount for its partial: LL <<0, HL <<16, LH <<16, HH <<32.
  - The accumulator is 64-bit modulo 2^64. Carries propagate fully across all 64 bits.
- **DRAIN:** lasts `MUL_PIPE` cycles and accumulates the products still in flight. A valid-bit shift register tagging each issued slot determines when `acc` updates.
- **FIX:** one cycle.
  - If `op`=10 or 11 and A[31]=1: `acc[63:32] -= B`.
  - If `op`=11 and B[31]=1: `acc[63:32] -= A`.
  - Both subtractions apply in the same cycle, modulo 2^32.
  - `op`=00 skips FIX and goes from DRAIN directly to DONE.
- **DONE:**
  - `resp_valid`=1 and `resp_result` = `acc[31:0]` for `op`=00, else `acc[63:32]`.
  - `resp_result` and `resp_valid` are held stable until `resp_ready`=1.
  - The block returns to IDLE on the edge where `resp_valid & resp_ready` is high.
  - It does not accept a new request in the same cycle. `req_ready` rises in the following cycle.
- **Ignored inputs:** operand changes on `req_*` while `busy` is high have no effect. `resp_ready` is ignored outside DONE.
- **Reset:** `reset_n`=0 sampled at any edge, including mid-operation:
  - state returns to IDLE;
  - `acc`, `k` and the pipe tags are cleared;
  - any in-flight product is discarded and never accumulated.

## Timing
- **Reset values:** `req_ready`=1, `resp_valid`=0, `resp_result`=0, `busy`=0.
- **Cycle numbering:** the accept edge ends cycle 0.
- **Issue cycles:** ISSUE occupies cycles 1..4 for mulx ops and cycles 1..3 for `mul`.
- **Latency, accept edge to first cycle with `resp_valid`=1:**
  - mulx ops: 4 + `MUL_PIPE` + 2 cycles, which is 7 for `MUL_PIPE`=1.
  - `mul`: 3 + `MUL_PIPE` + 1 cycles, which is 5 for `MUL_PIPE`=1.
- **Throughput:** at most one request per latency+1 cycles when `resp_ready` is held at 1.
- **Multiplier port:** the multiplier operand mux is registered-free. Operands are valid combinationally during ISSUE.

## Test plan
- **Latency, `mul`:** `op`=00, A=0x00010003, B=0x00020005, `resp_ready`=1 -> `resp_result`=0x000B000F with `resp_valid` first high 5 cycles after accept. Same operands with `op`=01 -> 0x00000002 at 7 cycles.
- **Unsigned carry chain:** `op`=01, A=B=0xFFFFFFFF -> 0xFFFFFFFE. `op`=00 with the same operands -> 0x00000001.
- **Signed correction:**
  - `op`=11, A=0xFFFFFFFF, B=0x00000002 -> 0xFFFFFFFF.
  - `op`=11, A=B=0x80000000 -> 0x40000000.
  - `op`=10, A=B=0xFFFFFFFF -> 0xFFFFFFFF.
- **Back-pressure:** hold `resp_ready`=0 for 3 cycles in DONE -> `resp_valid` and `resp_result` stay stable; `req_ready`=0 and `busy`=1 throughout; a pulsed `req_valid` is not accepted. Raising `resp_ready` -> IDLE on the next edge, and `req_ready`=1 one cycle later.
- **Reset mid-operation:** assert `reset_n`=0 for one edge during ISSUE k=2 -> all outputs at reset values on the next cycle. A new request `op`=01, A=3, B=5 then returns 0x00000000 with correct latency, and no stale partial product appears.
- **Back-to-back with random operands:** 1000 random (`op`, A, B) pairs with random `resp_ready` stalls -> every `resp_result` matches a 64-bit reference model. Also cover the `MUL_PIPE`=2 build, with latency 8 for mulx ops and 6 for `mul`.

Source files
------------

// File: rtl/nios2_c_cpu_mul_seq_if.sv
// Request/response bundle for the sequential 32x32 multiply unit.
// The issue stage is the master; the multiply sequencer is the slave.
interface nios2_c_cpu_mul_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        busy;

   modport master (
      output req_valid, req_op, req_src1, req_src2, resp_ready,
      input  req_ready, resp_valid, resp_result, busy
   );

   modport slave (
      input  req_valid, req_op, req_src1, req_src2, resp_ready,
      output req_ready, resp_valid, resp_result, busy
   );
endinterface

// File: rtl/nios2_c_cpu_mul_seq.sv
// Multi-cycle 32x32 multiply built around one shared 16x16 unsigned multiplier.
// Four partial products are issued on consecutive cycles, summed into a 64-bit
// accumulator as they leave the multiplier pipe, and then corrected for signed
// operands before the selected word is handed back.
// MUL_PIPE is the number of register stages in the multiplier (1 or 2).
module nios2_c_cpu_mul_seq #(
   parameter int MUL_PIPE = 1
) (
   input logic                    clk,
   input logic                    reset_n,
   nios2_c_cpu_mul_seq_if.slave   bus
);

   localparam int         LAST       = MUL_PIPE - 1;
   localparam logic [1:0] DRAIN_LAST = 2'(MUL_PIPE - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FIX,
      DONE
   } state_t;

   state_t      state;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [1:0]  op;
   logic [1:0]  k;
   logic [1:0]  drain_cnt;
   logic [63:0] acc;
   logic [63:0] acc_next;
   logic [63:0] addend;
   logic [31:0] fix_hi;

   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic        issue;

   logic [31:0] pipe_prod [MUL_PIPE];
   logic        pipe_vld  [MUL_PIPE];
   logic [1:0]  pipe_k    [MUL_PIPE];

   logic        req_ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_result_q;
   logic        busy_q;

   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.busy        = busy_q;

   // Bit 0 of k picks the half of A and bit 1 picks the half of B, which gives
   // the LL, HL, LH, HH issue order directly from the counter.
   assign mul_a = k[0] ? src1[31:16] : src1[15:0];
   assign mul_b = k[1] ? src2[31:16] : src2[15:0];
   assign issue = (state == ISSUE);

   // Shared multiplier pipe; each product travels with its slot tag and partial index.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < MUL_PIPE; i++) begin
            pipe_prod[i] <= '0;
            pipe_vld[i]  <= 1'b0;
            pipe_k[i]    <= '0;
         end
      end else begin
         pipe_prod[0] <= 32'(mul_a) * 32'(mul_b);
         pipe_vld[0]  <= issue;
         pipe_k[0]    <= k;
         for (int i = 1; i < MUL_PIPE; i++) begin
            pipe_prod[i] <= pipe_prod[i-1];
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_k[i]    <= pipe_k[i-1];
         end
      end
   end

   // Next accumulator value: either the aligned product leaving the pipe, or the
   // signed correction of the high word during FIX.
   always_comb begin
      addend = '0;
      case (pipe_k[LAST])
         2'd0:    addend = {32'b0, pipe_prod[LAST]};
         2'd3:    addend = {pipe_prod[LAST], 32'b0};
         default: addend = {16'b0, pipe_prod[LAST], 16'b0};
      endcase
      if (!pipe_vld[LAST]) begin
         addend = '0;
      end

      fix_hi = acc[63:32];
      if (op[1] && src1[31]) begin
         fix_hi = fix_hi - src2;
      end
      if ((op == 2'b11) && src2[31]) begin
         fix_hi = fix_hi - src1;
      end

      acc_next = acc + addend;
      if (state == FIX) begin
         acc_next = {fix_hi, acc[31:0]};
      end
   end

   // Sequencer: accept, issue partials, drain the pipe, correct, then hold the result.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         src1          <= '0;
         src2          <= '0;
         op            <= '0;
         k             <= '0;
         drain_cnt     <= '0;
         acc           <= '0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         acc <= acc_next;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  src1        <= bus.req_src1;
                  src2        <= bus.req_src2;
                  op          <= bus.req_op;
                  k           <= '0;
                  acc         <= '0;
                  state       <= ISSUE;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            ISSUE: begin
               k <= k + 2'd1;
               if ((k == 2'd3) || ((op == 2'b00) && (k == 2'd2))) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  if (op == 2'b00) begin
                     state         <= DONE;
                     resp_valid_q  <= 1'b1;
                     resp_result_q <= acc_next[31:0];
                  end else begin
                     state <= FIX;
                  end
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            FIX: begin
               state         <= DONE;
               resp_valid_q  <= 1'b1;
               resp_result_q <= acc_next[63:32];
            end
            DONE: begin
               if (bus.resp_ready) begin
                  state         <= IDLE;
                  resp_valid_q  <= 1'b0;
                  resp_result_q <= '0;
                  req_ready_q   <= 1'b1;
                  busy_q        <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_c_cpu_mul_seq.sv
// Testbench for nios2_c_cpu_mul_seq: a MUL_PIPE=1 and a MUL_PIPE=2 instance are
// driven with the same request stream and checked against hand-computed and
// reference-model results.
module tb_nios2_c_cpu_mul_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        resp_ready;

   int numChecks = 0;
   int numFails  = 0;

   nios2_c_cpu_mul_seq_if bus1 ();
   nios2_c_cpu_mul_seq_if bus2 ();

   assign bus1.req_valid  = req_valid;
   assign bus1.req_op     = req_op;
   assign bus1.req_src1   = req_src1;
   assign bus1.req_src2   = req_src2;
   assign bus1.resp_ready = resp_ready;
   assign bus2.req_valid  = req_valid;
   assign bus2.req_op     = req_op;
   assign bus2.req_src1   = req_src1;
   assign bus2.req_src2   = req_src2;
   assign bus2.resp_ready = resp_ready;

   nios2_c_cpu_mul_seq #(.MUL_PIPE(1)) dut1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   nios2_c_cpu_mul_seq #(.MUL_PIPE(2)) dut2 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus2)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case something never finishes
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: observed no end of test, expected end before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Full-width signed/unsigned reference product
   function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      ea = op[1] ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Wait (bounded) until both instances can take a request; called at a negedge
   task automatic waitIdle();
      for (int i = 0; i < 100; i++) begin
         if (bus1.req_ready && bus2.req_ready) return;
         @(negedge clk);
      end
      checkOutput("idle timeout", {62'b0, bus1.req_ready, bus2.req_ready}, 64'h3);
   endtask

   // One request with resp_ready held high; checks latency and result on both builds
   task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expected,
                                input int lat1Exp, input int lat2Exp);
      int          lat1 = 0;
      int          lat2 = 0;
      logic [31:0] res1 = '0;
      logic [31:0] res2 = '0;
      bit          seen1 = 1'b0;
      bit          seen2 = 1'b0;
      waitIdle();
      req_op     = op;
      req_src1   = a;
      req_src2   = b;
      req_valid  = 1'b1;
      resp_ready = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 40 && !(seen1 && seen2); c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (bus1.resp_valid && !seen1) begin
            seen1 = 1'b1;
            lat1  = c;
            res1  = bus1.resp_result;
         end
         if (bus2.resp_valid && !seen2) begin
            seen2 = 1'b1;
            lat2  = c;
            res2  = bus2.resp_result;
         end
      end
      checkOutput({tag, " lat pipe1"}, 64'(lat1), 64'(lat1Exp));
      checkOutput({tag, " lat pipe2"}, 64'(lat2), 64'(lat2Exp));
      checkOutput({tag, " res pipe1"}, {32'b0, res1}, {32'b0, expected});
      checkOutput({tag, " res pipe2"}, {32'b0, res2}, {32'b0, expected});
   endtask

   // Main sequence
   initial begin
      logic [31:0] expected;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      bit          done1;
      bit          done2;

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_src1   = '0;
      req_src2   = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("reset req_ready", {63'b0, bus1.req_ready}, 64'h1);
      checkOutput("reset resp_valid", {63'b0, bus1.resp_valid}, 64'h0);
      checkOutput("reset resp_result", {32'b0, bus1.resp_result}, 64'h0);
      checkOutput("reset busy", {63'b0, bus1.busy}, 64'h0);
      checkOutput("reset busy pipe2", {63'b0, bus2.busy}, 64'h0);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed vectors");
      applyStimulus("mul lat", 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 5, 6);
      applyStimulus("mulxuu lat", 2'b01, 32'h00010003, 32'h00020005, 32'h00000002, 7, 8);
      applyStimulus("mulxuu ones", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 7, 8);
      applyStimulus("mul ones", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5, 6);
      applyStimulus("mulxss m1x2", 2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 7, 8);
      applyStimulus("mulxss min", 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 7, 8);
      applyStimulus("mulxsu ones", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 8);

      $display("[TB] back-pressure");
      waitIdle();
      resp_ready = 1'b0;
      req_op     = 2'b11;
      req_src1   = 32'h80000000;
      req_src2   = 32'h80000000;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (bus1.resp_valid && bus2.resp_valid) break;
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp resp_valid", {63'b0, bus1.resp_valid}, 64'h1);
         checkOutput("bp resp_result", {32'b0, bus1.resp_result}, 64'h40000000);
         checkOutput("bp req_ready", {63'b0, bus1.req_ready}, 64'h0);
         checkOutput("bp busy", {63'b0, bus1.busy}, 64'h1);
         checkOutput("bp resp_result pipe2", {32'b0, bus2.resp_result}, 64'h40000000);
         req_valid = (i == 1);
         req_op    = 2'b00;
         req_src1  = 32'h00000005;
         req_src2  = 32'h00000007;
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp release resp_valid", {63'b0, bus1.resp_valid}, 64'h0);
      checkOutput("bp release req_ready", {63'b0, bus1.req_ready}, 64'h1);
      checkOutput("bp release busy", {63'b0, bus1.busy}, 64'h0);
      checkOutput("bp release busy pipe2", {63'b0, bus2.busy}, 64'h0);
      @(negedge clk);
      checkOutput("bp pulse ignored", {63'b0, bus1.busy}, 64'h0);

      $display("[TB] reset mid-operation");
      waitIdle();
      req_op    = 2'b01;
      req_src1  = 32'hFFFFFFFF;
      req_src2  = 32'hFFFFFFFF;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst req_ready", {63'b0, bus1.req_ready}, 64'h1);
      checkOutput("midrst resp_valid", {63'b0, bus1.resp_valid}, 64'h0);
      checkOutput("midrst resp_result", {32'b0, bus1.resp_result}, 64'h0);
      checkOutput("midrst busy", {63'b0, bus1.busy}, 64'h0);
      checkOutput("midrst busy pipe2", {63'b0, bus2.busy}, 64'h0);
      reset_n = 1'b1;
      @(negedge clk);
      applyStimulus("post reset mulxuu", 2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 7, 8);
      applyStimulus("post reset mul", 2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, 5, 6);

      $display("[TB] random back-to-back with stalls");
      for (int n = 0; n < 1000; n++) begin
         waitIdle();
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (n % 16 == 0) ra = 32'h80000000;
         if (n % 16 == 1) rb = 32'hFFFFFFFF;
         expected   = refModel(rop, ra, rb);
         req_op     = rop;
         req_src1   = ra;
         req_src2   = rb;
         req_valid  = 1'b1;
         resp_ready = 1'($urandom_range(0, 1));
         done1      = 1'b0;
         done2      = 1'b0;
         @(posedge clk);
         for (int c = 0; c < 80 && !(done1 && done2); c++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = 1'($urandom_range(0, 1));
            if (bus1.resp_valid && resp_ready && !done1) begin
               checkOutput("rand res pipe1", {32'b0, bus1.resp_result}, {32'b0, expected});
               done1 = 1'b1;
            end
            if (bus2.resp_valid && resp_ready && !done2) begin
               checkOutput("rand res pipe2", {32'b0, bus2.resp_result}, {32'b0, expected});
               done2 = 1'b1;
            end
         end
         if (!(done1 && done2)) begin
            checkOutput("rand timeout", {62'b0, done1, done2}, 64'h3);
         end
      end
      resp_ready = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
